// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed seven-segment scan controller with a one-deep write buffer
// Define SSEG_LZB_EN to enable leading-zero blanking of the anode drive.
module sseg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [4*NDIG-1:0] wr_data,
    output logic              wr_ready,
    output logic [3:0]        digit_nib,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [4*NDIG-1:0]  active_q, active_d;
    logic [4*NDIG-1:0]  pending_q, pending_d;
    logic               full_q, full_d;
    logic [3:0]         nib_q, nib_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic               fdone_q;
    logic               tick, boundary, blank;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (tick)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        active_d  = active_q;
        pending_d = pending_q;
        full_d    = full_q;
        if (boundary && full_q) begin
            active_d = pending_q;
            full_d   = 1'b0;
        end
        // A write accepted on the boundary cycle lands in pending only.
        if (wr_valid && !full_q) begin
            pending_d = wr_data;
            full_d    = 1'b1;
        end

        // Outputs are computed from next-state values so they line up with the new slot.
        nib_d = active_d[4*idx_d +: 4];

        blank = 1'b0;
`ifdef SSEG_LZB_EN
        blank = (idx_d != '0);
        for (int k = 0; k < NDIG; k++) begin
            if (k >= int'(idx_d) && active_d[4*k +: 4] != 4'h0)
                blank = 1'b0;
        end
`endif

        an_d = '1;
        if (cnt_d >= GUARD_C && !blank)
            an_d[idx_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            full_q    <= 1'b0;
            nib_q     <= '0;
            an_q      <= '1;
            fdone_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            full_q    <= full_d;
            nib_q     <= nib_d;
            an_q      <= an_d;
            fdone_q   <= boundary;
        end
    end

    assign wr_ready   = !full_q;
    assign digit_nib  = nib_q;
    assign an         = an_q;
    assign frame_done = fdone_q;
endmodule
